// File: rtl/aes_pkg.sv
// AES primitives shared by the iterative encryption core and its key schedule.
// Latency: purely combinational functions; no state is held here.
// Backpressure: not applicable; this package carries no handshakes.
package aes_pkg;

  typedef logic [127:0] aes_block_t;
  typedef logic [31:0]  aes_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_DONE
  } aes_fsm_e;

  // Round constants; entry i feeds key-schedule step i.
  localparam logic [7:0] RCON [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
    endcase
    return s;
  endfunction

  // Multiply by x in GF(2^8) with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_word_t sub_word(input aes_word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic aes_block_t sub_bytes(input aes_block_t s);
    aes_block_t o;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    end
    return o;
  endfunction

  // Byte k sits at row k%4, column k/4; row r rotates left by r columns.
  function automatic aes_block_t shift_rows(input aes_block_t s);
    aes_block_t o;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic aes_block_t mix_columns(input aes_block_t s);
    aes_block_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One on-the-fly key-schedule step: current round key plus the advanced key window.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to register the next window.
module aes_key_step
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 256
) (
  input  logic [KEY_BITS-1:0] key_i,
  input  logic [3:0]          step_i,
  output logic [KEY_BITS-1:0] next_o,
  output logic [127:0]        rk_o
);

  if (KEY_BITS == 128) begin : g_k128
    // Window holds rk[step-1]; this step derives rk[step], which is also the next window.
    logic [3:0] rc_raw;
    logic [3:0] rc_idx;
    aes_word_t  t, w0, w1, w2, w3;
    assign rc_raw = step_i - 4'd1;
    assign rc_idx = (rc_raw > 4'd9) ? 4'd9 : rc_raw;
    assign t  = sub_word(rot_word(key_i[31:0])) ^ {RCON[rc_idx], 24'h0};
    assign w0 = key_i[127:96] ^ t;
    assign w1 = key_i[95:64]  ^ w0;
    assign w2 = key_i[63:32]  ^ w1;
    assign w3 = key_i[31:0]   ^ w2;
    assign rk_o   = {w0, w1, w2, w3};
    assign next_o = {w0, w1, w2, w3};
  end else begin : g_k256
    // Window holds {rk[step-1], rk[step]}; the low half is this round's key and the
    // new half rk[step+1] uses RotWord+Rcon on odd steps and SubWord only on even steps.
    logic [3:0] rc_raw;
    logic [3:0] rc_idx;
    aes_word_t  t, w0, w1, w2, w3;
    assign rc_raw = (step_i - 4'd1) >> 1;
    assign rc_idx = (rc_raw > 4'd9) ? 4'd9 : rc_raw;
    assign t  = step_i[0] ? (sub_word(rot_word(key_i[31:0])) ^ {RCON[rc_idx], 24'h0})
                          : sub_word(key_i[31:0]);
    assign w0 = key_i[255:224] ^ t;
    assign w1 = key_i[223:192] ^ w0;
    assign w2 = key_i[191:160] ^ w1;
    assign w3 = key_i[159:128] ^ w2;
    assign rk_o   = key_i[127:0];
    assign next_o = {key_i[127:0], w0, w1, w2, w3};
  end

endmodule

// File: rtl/aes_iter_enc.sv
// Iterative AES-128/256 encryption, one round per clock, round keys derived on the fly.
// Latency: out_valid rises NR clocks after the accepting edge; one block per NR+1 cycles.
// Backpressure: result held in DONE until out_ready; in_ready follows out_ready there.
module aes_iter_enc
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 256,
  parameter int TAG_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [KEY_BITS-1:0] in_key,
  input  logic [127:0]        in_data,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic [TAG_W-1:0]    out_tag,
  output logic                busy
);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_iter_enc: KEY_BITS must be 128 or 256");
  end

  localparam int         NR   = (KEY_BITS == 128) ? 10 : 14;
  localparam logic [3:0] NR_L = 4'(NR);

  aes_fsm_e            fsm_q, fsm_d;
  aes_block_t          state_q, state_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [3:0]          rnd_q, rnd_d;

  logic [KEY_BITS-1:0] key_next;
  aes_block_t          rk_cur;
  aes_block_t          rk0;
  aes_block_t          sr_out;
  aes_block_t          round_out;
  logic                accept;

  aes_key_step #(.KEY_BITS(KEY_BITS)) u_key_step (
    .key_i  (key_q),
    .step_i (rnd_q),
    .next_o (key_next),
    .rk_o   (rk_cur)
  );

  // Round key 0 is the first 128 bits of the cipher key for both key sizes.
  assign rk0       = in_key[KEY_BITS-1 -: 128];
  assign sr_out    = shift_rows(sub_bytes(state_q));
  assign round_out = ((rnd_q == NR_L) ? sr_out : mix_columns(sr_out)) ^ rk_cur;

  assign out_data = state_q;
  assign out_tag  = tag_q;

  // Next-state and handshake decode; an accept from IDLE or DONE loads the same way.
  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    key_d     = key_q;
    tag_d     = tag_q;
    rnd_d     = rnd_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      ST_ROUND: begin
        busy    = 1'b1;
        state_d = round_out;
        key_d   = key_next;
        rnd_d   = rnd_q + 4'd1;
        if (rnd_q == NR_L) begin
          fsm_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            accept = 1'b1;
          end else begin
            fsm_d = ST_IDLE;
          end
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
    if (accept) begin
      state_d = in_data ^ rk0;
      key_d   = in_key;
      tag_d   = in_tag;
      rnd_d   = 4'd1;
      fsm_d   = ST_ROUND;
    end
  end

  // State, key window, tag and round counter registers; reset discards any in-flight block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      key_q   <= '0;
      tag_q   <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      tag_q   <= tag_d;
      rnd_q   <= rnd_d;
    end
  end

endmodule

// File: tb/tb_aes_iter_enc.sv
// Directed bench for aes_iter_enc: AES-256 and AES-128 instances checked against known answers.
// Expected results are queued on every accept and popped on every output handshake.
module tb_aes_iter_enc;

  localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] K128A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT128A = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT128A = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K128B  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT128B = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct packed {
    logic [7:0]   tag;
    logic [127:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [255:0] a_in_key;
  logic [127:0] a_in_data, a_out_data;
  logic [7:0]   a_in_tag, a_out_tag;

  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [127:0] b_in_key;
  logic [127:0] b_in_data, b_out_data;
  logic [7:0]   b_in_tag, b_out_tag;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  aes_iter_enc #(.KEY_BITS(256), .TAG_W(8)) dut256 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_key(a_in_key),
    .in_data(a_in_data), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_tag(a_out_tag), .busy(a_busy)
  );

  aes_iter_enc #(.KEY_BITS(128), .TAG_W(8)) dut128 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_key(b_in_key),
    .in_data(b_in_data), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_tag(b_out_tag), .busy(b_busy)
  );

  task automatic check(input string nm, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", nm, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one block to the 256-bit core and queue its expected result once accepted.
  task automatic send_a(input logic [255:0] key, input logic [127:0] pt,
                        input logic [7:0] tag, input logic [127:0] ct);
    bit rdy;
    rdy = 1'b0;
    a_in_key = key; a_in_data = pt; a_in_tag = tag; a_in_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      rdy = a_in_ready;
      tick();
      if (rdy) break;
    end
    a_in_valid = 1'b0;
    check("a_accept", 128'(rdy), 128'd1);
    if (rdy) sb_a.push_back({tag, ct});
  endtask

  task automatic wait_a(input string nm, input int exp_lat);
    int lat;
    lat = 0;
    while (!a_out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({nm, "_latency"}, 128'(lat), 128'(exp_lat));
  endtask

  task automatic hs_a(input string nm);
    exp_t e;
    e = 'x;
    if (sb_a.size() > 0) e = sb_a.pop_front();
    check({nm, "_data"}, a_out_data, e.data);
    check({nm, "_tag"}, 128'(a_out_tag), 128'(e.tag));
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    check({nm, "_valid_drop"}, 128'(a_out_valid), 128'd0);
  endtask

  task automatic run128(input string nm, input logic [127:0] key, input logic [127:0] pt,
                        input logic [7:0] tag, input logic [127:0] ct);
    bit   rdy;
    int   lat;
    exp_t e;
    rdy = 1'b0;
    b_in_key = key; b_in_data = pt; b_in_tag = tag; b_in_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      rdy = b_in_ready;
      tick();
      if (rdy) break;
    end
    b_in_valid = 1'b0;
    check({nm, "_accept"}, 128'(rdy), 128'd1);
    if (rdy) sb_b.push_back({tag, ct});
    lat = 0;
    while (!b_out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({nm, "_latency"}, 128'(lat), 128'd10);
    e = 'x;
    if (sb_b.size() > 0) e = sb_b.pop_front();
    check({nm, "_data"}, b_out_data, e.data);
    check({nm, "_tag"}, 128'(b_out_tag), 128'(e.tag));
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    check({nm, "_idle"}, 128'(b_in_ready), 128'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   acc, hs, seen;
    int   cyc, n_out, sent;
    int   t_out[2];

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_key = '0; a_in_data = '0; a_in_tag = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_key = '0; b_in_data = '0; b_in_tag = '0;
    tick();
    tick();

    // Reset values.
    check("rst_out_valid", 128'(a_out_valid), 128'd0);
    check("rst_busy", 128'(a_busy), 128'd0);
    check("rst_out_data", a_out_data, 128'd0);
    check("rst_out_tag", 128'(a_out_tag), 128'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 128'(a_in_ready), 128'd1);
    check("post_rst_in_ready_128", 128'(b_in_ready), 128'd1);

    // AES-256 known answer with latency and busy.
    send_a(K256, PT, 8'h5a, CT256);
    check("t1_busy", 128'(a_busy), 128'd1);
    wait_a("t1", 14);
    hs_a("t1");
    check("t1_idle_ready", 128'(a_in_ready), 128'd1);

    // AES-128 known answers.
    run128("t2a", K128A, PT128A, 8'hc3, CT128A);
    run128("t2b", K128B, PT, 8'h3c, CT128B);

    // Backpressure: result held, input side closed, stray in_valid ignored.
    send_a(K256, PT, 8'h33, CT256);
    wait_a("t3", 14);
    for (int i = 0; i < 5; i++) begin
      a_in_valid = (i % 2 == 1);
      a_in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      a_in_tag   = 8'hff;
      tick();
      check("t3_hold_data", a_out_data, sb_a[0].data);
      check("t3_hold_tag", 128'(a_out_tag), 128'(sb_a[0].tag));
      check("t3_in_ready_low", 128'(a_in_ready), 128'd0);
    end
    a_in_valid = 1'b0;
    hs_a("t3");
    check("t3_back_idle", 128'(a_in_ready), 128'd1);
    check("t3_not_busy", 128'(a_busy), 128'd0);

    // Back-to-back with in_valid and out_ready held high.
    a_out_ready = 1'b1;
    a_in_key = K256; a_in_data = PT; a_in_tag = 8'h01; a_in_valid = 1'b1;
    cyc = 0; n_out = 0; sent = 0;
    t_out[0] = 0; t_out[1] = 0;
    while (n_out < 2 && cyc < 200) begin
      acc = a_in_valid && a_in_ready;
      hs  = a_out_valid && a_out_ready;
      if (hs) begin
        exp_t e;
        e = 'x;
        if (sb_a.size() > 0) e = sb_a.pop_front();
        check("t4_data", a_out_data, e.data);
        check("t4_tag", 128'(a_out_tag), 128'(e.tag));
        if (n_out == 0) check("t4_accept_on_hs", 128'(acc), 128'd1);
        t_out[n_out] = cyc;
        n_out++;
      end
      tick();
      cyc++;
      if (acc) begin
        sb_a.push_back({a_in_tag, CT256});
        sent++;
        if (sent == 1) a_in_tag = 8'h02;
        else a_in_valid = 1'b0;
      end
    end
    a_out_ready = 1'b0;
    a_in_valid  = 1'b0;
    check("t4_outputs", 128'(n_out), 128'd2);
    check("t4_spacing", 128'(t_out[1] - t_out[0]), 128'd15);

    // Reset during round 7 discards the block.
    send_a(K256, PT, 8'h77, CT256);
    repeat (6) tick();
    check("t5_busy_rnd7", 128'(a_busy), 128'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", 128'(a_out_valid), 128'd0);
    check("t5_rst_busy", 128'(a_busy), 128'd0);
    sb_a.delete();
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_in_ready", 128'(a_in_ready), 128'd1);
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen = seen | a_out_valid;
    end
    check("t5_no_output", 128'(seen), 128'd0);
    send_a(K256, PT, 8'h05, CT256);
    wait_a("t5", 14);
    hs_a("t5");

    // Inputs changed right after accept must not affect the result.
    send_a(K256, PT, 8'h66, CT256);
    a_in_key = ~K256; a_in_data = ~PT; a_in_tag = 8'h99;
    wait_a("t6", 14);
    hs_a("t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
